// File: rtl/ptp_ts_fifo_if.sv
// Bus-register and timestamp-capture signals of one PTP timestamp queue.
// slave = the queue itself, master = the bus/capture side driving it.
interface ptp_ts_fifo_if;
  logic [31:0] bus2ip_addr_i;
  logic [31:0] bus2ip_data_i;
  logic        bus2ip_rd_ce_i;
  logic        bus2ip_wr_ce_i;
  logic [31:0] ip2bus_data_o;
  logic        ts_valid_i;
  logic [47:0] ts_sec_i;
  logic [31:0] ts_ns_i;
  logic [15:0] ts_seqid_i;
  logic [3:0]  ts_msgtype_i;
  logic        ts_int_o;

  modport slave (
    input  bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
    input  ts_valid_i, ts_sec_i, ts_ns_i, ts_seqid_i, ts_msgtype_i,
    output ip2bus_data_o, ts_int_o
  );

  modport master (
    output bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
    output ts_valid_i, ts_sec_i, ts_ns_i, ts_seqid_i, ts_msgtype_i,
    input  ip2bus_data_o, ts_int_o
  );
endinterface

// File: rtl/ptp_ts_fifo.sv
// PTP timestamp queue read through 32-bit registers at TS_BASE_ADDR+0..+5; head data combinational, pop/int one cycle later.
// No backpressure: full captures are dropped with ovf set, or overwrite the oldest entry when PTP_TS_FIFO_OVERWRITE_EN is defined.
module ptp_ts_fifo #(
  parameter logic [31:0] TS_BASE_ADDR = 32'h310,
  parameter int          DEPTH        = 4,
  parameter int          AW           = 2
) (
  input  logic          bus2ip_clk,
  input  logic          bus2ip_rst_n,
  ptp_ts_fifo_if.slave  bus
);

  typedef struct packed {
    logic [3:0]  msgtype;
    logic [15:0] seqid;
    logic [47:0] sec;
    logic [31:0] ns;
  } ts_entry_t;

  ts_entry_t     mem [DEPTH];
  ts_entry_t     head;
  ts_entry_t     wr_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          ovf;
  logic          ts_int;
  logic          rd_ce_z1;
  logic [31:0]   addr_z1;
  logic          empty;
  logic          full;
  logic          access_end;
  logic          pop_req;
  logic          stat_clr;
  logic          flush;
  logic          do_push;
  logic          do_pop;
  logic          rd_adv;
  logic          ovf_set;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          unused_data;

  assign unused_data = ^bus.bus2ip_data_i[31:1];

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // An access ends when rd_ce drops or the address moves while rd_ce stays high.
  assign access_end = rd_ce_z1 && (!bus.bus2ip_rd_ce_i || (bus.bus2ip_addr_i != addr_z1));
  assign pop_req    = access_end && (addr_z1 == TS_BASE_ADDR + 32'd4);
  assign stat_clr   = access_end && (addr_z1 == TS_BASE_ADDR);
  assign flush      = bus.bus2ip_wr_ce_i && (bus.bus2ip_addr_i == TS_BASE_ADDR + 32'd5) &&
                      bus.bus2ip_data_i[0];

  assign wr_entry = '{msgtype: bus.ts_msgtype_i, seqid: bus.ts_seqid_i,
                      sec: bus.ts_sec_i, ns: bus.ts_ns_i};

  always_comb begin
    do_pop    = pop_req && !empty && !flush;
    do_push   = 1'b0;
    rd_adv    = do_pop;
    ovf_set   = 1'b0;
    count_nxt = count;
    if (bus.ts_valid_i && !flush) begin
      if (!full || do_pop) begin
        do_push = 1'b1;
      end else begin
        ovf_set = 1'b1;
`ifdef PTP_TS_FIFO_OVERWRITE_EN
        do_push = 1'b1;
        rd_adv  = 1'b1;
`endif
      end
    end
    case ({do_push, rd_adv})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      ts_int   <= 1'b0;
      rd_ce_z1 <= 1'b0;
      addr_z1  <= '0;
    end else begin
      rd_ce_z1 <= bus.bus2ip_rd_ce_i;
      addr_z1  <= bus.bus2ip_addr_i;
      ts_int   <= do_push;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (rd_adv)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_nxt;
      end
      // A fresh overflow in the same cycle as a STATUS read end keeps ovf set.
      if (ovf_set)       ovf <= 1'b1;
      else if (stat_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge bus2ip_clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  assign head   = empty ? '0 : mem[rd_ptr];
  assign status = {23'b0, ovf, 1'b0, empty, 6'(count)};

  always_comb begin
    rdata = '0;
    if (bus.bus2ip_rd_ce_i) begin
      case (bus.bus2ip_addr_i)
        TS_BASE_ADDR:          rdata = status;
        TS_BASE_ADDR + 32'd1:  rdata = {16'b0, head.sec[47:32]};
        TS_BASE_ADDR + 32'd2:  rdata = head.sec[31:0];
        TS_BASE_ADDR + 32'd3:  rdata = head.ns;
        TS_BASE_ADDR + 32'd4:  rdata = {12'b0, head.msgtype, head.seqid};
        default:               rdata = '0;
      endcase
    end
  end

  assign bus.ip2bus_data_o = rdata;
  assign bus.ts_int_o      = ts_int;

endmodule

// File: tb/tb_ptp_ts_fifo.sv
// Randomized and directed checks of ptp_ts_fifo against a queue-based model of the register view.
`timescale 1ns/1ps
module tb_ptp_ts_fifo;
  localparam logic [31:0] BASE  = 32'h310;
  localparam int          DEPTH = 4;

  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] seqid;
    logic [3:0]  mt;
  } ent_t;

  logic bus2ip_clk   = 1'b0;
  logic bus2ip_rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  int   m_pulses = 0;
  bit   m_ovf = 1'b0;
  ent_t q[$];

  ptp_ts_fifo_if bus();

  ptp_ts_fifo #(.TS_BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(2)) dut (
    .bus2ip_clk  (bus2ip_clk),
    .bus2ip_rst_n(bus2ip_rst_n),
    .bus         (bus)
  );

  always #5 bus2ip_clk = ~bus2ip_clk;

  always @(negedge bus2ip_clk) if (bus.ts_int_o === 1'b1) pulses++;

  function automatic logic [31:0] exp_reg(input int off);
    if (off == 0) return (m_ovf ? 32'h100 : 32'h0) | (q.size() == 0 ? 32'h40 : 32'h0) | q.size();
    if (q.size() == 0) return 32'h0;
    case (off)
      1: return {16'h0, q[0].sec[47:32]};
      2: return q[0].sec[31:0];
      3: return q[0].ns;
      4: return {12'h0, q[0].mt, q[0].seqid};
      default: return 32'h0;
    endcase
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.sec   = {16'($urandom), 32'($urandom)};
    e.ns    = $urandom;
    e.seqid = 16'($urandom);
    e.mt    = 4'($urandom);
    return e;
  endfunction

  function automatic void m_push(input ent_t e);
    if (q.size() < DEPTH) begin
      q.push_back(e);
      m_pulses++;
    end else begin
      m_ovf = 1'b1;
`ifdef PTP_TS_FIFO_OVERWRITE_EN
      void'(q.pop_front());
      q.push_back(e);
      m_pulses++;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge bus2ip_clk);
    #1;
  endtask

  task automatic set_ts(input ent_t e, input logic v);
    bus.ts_valid_i   = v;
    bus.ts_sec_i     = e.sec;
    bus.ts_ns_i      = e.ns;
    bus.ts_seqid_i   = e.seqid;
    bus.ts_msgtype_i = e.mt;
  endtask

  task automatic push(input ent_t e);
    set_ts(e, 1'b1);
    tick();
    bus.ts_valid_i = 1'b0;
    m_push(e);
  endtask

  // Single-word read access; model side effects applied once the access has ended.
  task automatic rd(input int off, output logic [31:0] d);
    bus.bus2ip_rd_ce_i = 1'b1;
    bus.bus2ip_addr_i  = BASE + 32'(off);
    #2 d = bus.ip2bus_data_o;
    tick();
    bus.bus2ip_rd_ce_i = 1'b0;
    tick();
    if (off == 4 && q.size() > 0) void'(q.pop_front());
    if (off == 0) m_ovf = 1'b0;
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    bus.bus2ip_wr_ce_i = 1'b1;
    bus.bus2ip_addr_i  = BASE + 32'(off);
    bus.bus2ip_data_i  = data;
    tick();
    bus.bus2ip_wr_ce_i = 1'b0;
    if (off == 5 && data[0]) q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    ent_t z;
    z = '{default: '0};
    set_ts(z, 1'b0);
    bus.bus2ip_addr_i = '0; bus.bus2ip_data_i = '0;
    bus.bus2ip_rd_ce_i = 1'b0; bus.bus2ip_wr_ce_i = 1'b0;
    #12;
    tests++; if (bus.ts_int_o !== 1'b0) begin fails++; $display("FAIL reset_int got %b exp 0", bus.ts_int_o); end
    tests++; if (bus.ip2bus_data_o !== 32'h0) begin fails++; $display("FAIL reset_idle_data got %h exp 0", bus.ip2bus_data_o); end
    @(negedge bus2ip_clk) bus2ip_rst_n = 1'b1;
    tick();
    rd(0, d);
    tests++; if (d !== 32'h40) begin fails++; $display("FAIL reset_status got %h exp 00000040", d); end
    for (int i = 1; i <= 5; i++) begin
      rd(i, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_reg%0d got %h exp 0", i, d); end
    end
  endtask

  task automatic test_single();
    logic [31:0] d, e;
    ent_t t;
    t.sec = 48'h0000_1234_5678; t.ns = 32'h1DCD_6500; t.seqid = 16'h00A5; t.mt = 4'h3;
    push(t);
    tests++; if (bus.ts_int_o !== 1'b1) begin fails++; $display("FAIL single_int_hi got %b exp 1", bus.ts_int_o); end
    tick();
    tests++; if (bus.ts_int_o !== 1'b0) begin fails++; $display("FAIL single_int_lo got %b exp 0", bus.ts_int_o); end
    rd(0, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL single_status got %h exp 00000001", d); end
    for (int i = 1; i <= 4; i++) begin
      e = exp_reg(i);
      rd(i, d);
      tests++; if (d !== e) begin fails++; $display("FAIL single_reg%0d got %h exp %h", i, d, e); end
    end
    rd(0, d);
    tests++; if (d !== 32'h40) begin fails++; $display("FAIL single_after_pop got %h exp 00000040", d); end
  endtask

  task automatic test_empty_pop();
    logic [31:0] d;
    rd(4, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL empty_pop_data got %h exp 0", d); end
    rd(0, d);
    tests++; if (d !== 32'h40) begin fails++; $display("FAIL empty_pop_status got %h exp 00000040", d); end
    rd(6, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read got %h exp 0", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    int p0;
    p0 = pulses;
    for (int i = 0; i < 5; i++) push(rand_ent());
    tick();
    tests++; if (pulses - p0 !== m_pulses - (m_pulses - (pulses - p0)) || (pulses != m_pulses))
      begin fails++; $display("FAIL ovf_pulses got %0d exp %0d", pulses, m_pulses); end
    e = exp_reg(0);
    rd(0, d);
    tests++; if (d !== e || d !== 32'h104) begin fails++; $display("FAIL ovf_status got %h exp %h", d, e); end
    rd(0, d);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL ovf_cleared got %h exp 00000004", d); end
    for (int i = 0; i < 4; i++) begin
      for (int r = 1; r <= 4; r++) begin
        e = exp_reg(r);
        rd(r, d);
        tests++; if (d !== e) begin fails++; $display("FAIL ovf_drain%0d_reg%0d got %h exp %h", i, r, d, e); end
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d, e;
    ent_t n;
    for (int i = 0; i < 4; i++) push(rand_ent());
    n = rand_ent();
    e = exp_reg(4);
    bus.bus2ip_rd_ce_i = 1'b1;
    bus.bus2ip_addr_i  = BASE + 32'd4;
    #2 d = bus.ip2bus_data_o;
    tests++; if (d !== e) begin fails++; $display("FAIL pp_head got %h exp %h", d, e); end
    tick();
    bus.bus2ip_rd_ce_i = 1'b0;
    set_ts(n, 1'b1);
    tick();
    bus.ts_valid_i = 1'b0;
    void'(q.pop_front());
    m_push(n);
    tick();
    tests++; if (pulses != m_pulses) begin fails++; $display("FAIL pp_pulses got %0d exp %0d", pulses, m_pulses); end
    e = exp_reg(0);
    rd(0, d);
    tests++; if (d !== e || d !== 32'h4) begin fails++; $display("FAIL pp_status got %h exp %h", d, e); end
    for (int i = 0; i < 4; i++) begin
      e = exp_reg(4);
      rd(4, d);
      tests++; if (d !== e) begin fails++; $display("FAIL pp_drain%0d got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_burst();
    logic [31:0] d, e;
    int seq[5] = '{1, 2, 3, 4, 1};
    push(rand_ent());
    push(rand_ent());
    bus.bus2ip_rd_ce_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.bus2ip_addr_i = BASE + 32'(seq[i]);
      e = exp_reg(seq[i]);
      #2 d = bus.ip2bus_data_o;
      tests++; if (d !== e) begin fails++; $display("FAIL burst_step%0d got %h exp %h", i, d, e); end
      tick();
    end
    bus.bus2ip_rd_ce_i = 1'b0;
    tick();
    void'(q.pop_front());
    e = exp_reg(0);
    rd(0, d);
    tests++; if (d !== e || d !== 32'h1) begin fails++; $display("FAIL burst_status got %h exp %h", d, e); end
    e = exp_reg(3);
    rd(3, d);
    tests++; if (d !== e) begin fails++; $display("FAIL burst_next_head got %h exp %h", d, e); end
    wr(5, 32'h1);
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    int p0;
    for (int i = 0; i < 5; i++) push(rand_ent());
    rd(5, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL ctrl_read got %h exp 0", d); end
    p0 = pulses;
    bus.bus2ip_wr_ce_i = 1'b1;
    bus.bus2ip_addr_i  = BASE + 32'd5;
    bus.bus2ip_data_i  = 32'h1;
    set_ts(rand_ent(), 1'b1);
    tick();
    bus.bus2ip_wr_ce_i = 1'b0;
    bus.ts_valid_i     = 1'b0;
    q.delete();
    tick();
    tests++; if (pulses != p0) begin fails++; $display("FAIL flush_no_pulse got %0d exp %0d", pulses - p0, 0); end
    e = exp_reg(0);
    rd(0, d);
    tests++; if (d !== e || d !== 32'h140) begin fails++; $display("FAIL flush_status got %h exp %h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) push(rand_ent());
    #2 bus2ip_rst_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    bus.bus2ip_rd_ce_i = 1'b1;
    bus.bus2ip_addr_i  = BASE;
    #1 d = bus.ip2bus_data_o;
    tests++; if (d !== 32'h40) begin fails++; $display("FAIL rst_mid_in_reset got %h exp 00000040", d); end
    bus.bus2ip_rd_ce_i = 1'b0;
    @(negedge bus2ip_clk) bus2ip_rst_n = 1'b1;
    tick();
    rd(0, d);
    tests++; if (d !== 32'h40) begin fails++; $display("FAIL rst_mid_status got %h exp 00000040", d); end
    rd(2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_head got %h exp 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int op, off;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        push(rand_ent());
      end else if (op < 9) begin
        off = $urandom_range(0, 5);
        e = exp_reg(off);
        rd(off, d);
        tests++; if (d !== e) begin fails++; $display("FAIL rand%0d_reg%0d got %h exp %h", i, off, d, e); end
      end else begin
        wr(5, $urandom);
      end
    end
    tick();
    tests++; if (pulses != m_pulses) begin fails++; $display("FAIL rand_pulses got %0d exp %0d", pulses, m_pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_pop();
    test_overflow();
    test_push_pop_full();
    test_burst();
    test_flush();
    test_reset_mid();
    m_pulses = pulses;
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
